// File: rtl/modulo_divisor_programavel.sv
// Multi-channel programmable frequency divider: per-channel runtime divisor with
// glitch-free shadow loading, one-cycle tick, 50% clk_div and free-run/one-shot modes.
module modulo_divisor_programavel #(
    parameter int N_CH        = 2,
    parameter int WIDTH       = 20,
    parameter int DEFAULT_DIV = 8,
    parameter int SEL_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             enable,
    input  logic             div_load,
    input  logic [SEL_W-1:0] div_sel,
    input  logic [WIDTH-1:0] div_value,
    input  logic [N_CH-1:0]  mode,
    input  logic [N_CH-1:0]  restart,
    output logic [N_CH-1:0]  tick,
    output logic [N_CH-1:0]  clk_div,
    output logic [N_CH-1:0]  done,
    output logic             load_err
);

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);

    logic sel_ok;
    logic load_ok;

    assign sel_ok  = int'(div_sel) < N_CH;
    assign load_ok = div_load && (div_value != '0) && sel_ok;

    always_ff @(posedge clk) begin
        if (clr) begin
            load_err <= 1'b0;
        end else begin
            load_err <= div_load && ((div_value == '0) || !sel_ok);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [WIDTH-1:0] cnt;
        logic [WIDTH-1:0] div;
        logic [WIDTH-1:0] shadow;
        logic             pending;
        logic             tick_r;
        logic             clk_div_r;
        logic             done_r;

        logic             hit;
        logic [WIDTH-1:0] eff_div;
        logic             eff_pend;
        logic             terminal;

        // A load landing in this very cycle is visible to the terminal count / restart below.
        assign hit      = load_ok && (div_sel == SEL_W'(i));
        assign eff_div  = hit ? div_value : shadow;
        assign eff_pend = hit || pending;
        assign terminal = (cnt == div - WIDTH'(1));

        // NOTE: state uses non-blocking assignments; the default shadow/pending update is
        // written first so the later branches can override it without ordering hazards.
        always_ff @(posedge clk) begin
            if (clr) begin
                cnt       <= '0;
                div       <= DEF_DIV;
                shadow    <= DEF_DIV;
                pending   <= 1'b0;
                tick_r    <= 1'b0;
                clk_div_r <= 1'b0;
                done_r    <= 1'b0;
            end else begin
                shadow  <= eff_div;
                pending <= eff_pend;
                if (restart[i]) begin
                    cnt       <= '0;
                    clk_div_r <= 1'b0;
                    done_r    <= 1'b0;
                    tick_r    <= 1'b0;
                    pending   <= 1'b0;
                    if (eff_pend) begin
                        div <= eff_div;
                    end
                end else if (enable && !done_r) begin
                    if (terminal) begin
                        cnt       <= '0;
                        tick_r    <= 1'b1;
                        clk_div_r <= ~clk_div_r;
                        if (eff_pend) begin
                            div     <= eff_div;
                            pending <= 1'b0;
                        end
                        if (mode[i]) begin
                            done_r <= 1'b1;
                        end
                    end else begin
                        cnt    <= cnt + WIDTH'(1);
                        tick_r <= 1'b0;
                    end
                end else begin
                    tick_r <= 1'b0;
                end
            end
        end

        assign tick[i]    = tick_r;
        assign clk_div[i] = clk_div_r;
        assign done[i]    = done_r;
    end

endmodule
